// File: rtl/lmring_pkg.sv
// Shared ring-packet layout, identity widths and LMM address width.
package lmring_pkg;

  localparam int unsigned CHIP_BITS        = 4;
  localparam int unsigned EXRING_ADDR_BITS = 16;

  // Packet layout, LSB first: d, dm, a, av, sq, col, ty, rw
  function automatic int unsigned off_d(input int unsigned dw);
    return 0 * dw;
  endfunction

  function automatic int unsigned off_dm(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned off_a(input int unsigned dw);
    return dw + dw / 8;
  endfunction

  function automatic int unsigned off_av(input int unsigned dw);
    return off_a(dw) + 32;
  endfunction

  function automatic int unsigned off_sq(input int unsigned dw);
    return off_av(dw) + 1;
  endfunction

  function automatic int unsigned off_col(input int unsigned dw);
    return off_sq(dw) + 8;
  endfunction

  function automatic int unsigned off_ty(input int unsigned dw, input int unsigned colb);
    return off_col(dw) + colb;
  endfunction

  function automatic int unsigned off_rw(input int unsigned dw, input int unsigned colb);
    return off_ty(dw, colb) + 3;
  endfunction

  function automatic int unsigned br_bits(input int unsigned ncol, input int unsigned dw);
    return off_rw(dw, $clog2(ncol)) + 1;
  endfunction

  // Ring packet width for the default NCOL=4, DW=256 build
  localparam int unsigned BR_BITS = br_bits(4, 256);

endpackage

// File: rtl/nbit_ndepth_queue.sv
// W-bit, DEPTH-entry FIFO; head is presented combinationally and gated to zero when empty.
module nbit_ndepth_queue #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [W-1:0]                 data_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 head_c_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next pointers and occupancy; push and pop may coincide
  always_comb begin
    do_pop = pop_i && (cnt_q != '0);
    wr_d   = push_i ? ptr_inc(wr_q) : wr_q;
    rd_d   = do_pop ? ptr_inc(rd_q) : rd_q;
    cnt_d  = cnt_q;
    if (push_i && !do_pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!push_i && do_pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Pointer and count state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  assign head_c_o = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count_o  = cnt_q;

endmodule

// File: rtl/lmring_node.sv
// Ring node: LMM window decode, credit-based accept, fixed-latency read merge, output FIFO.
module lmring_node
  import lmring_pkg::*;
#(
  parameter int unsigned NCOL   = 4,
  parameter int unsigned DW     = 256,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                          ACLK,
  input  logic                          RSTN,
  input  logic [CHIP_BITS-1:0]          chip,
  input  logic [5:0]                    l_row,
  input  logic [NCOL*32-1:0]            cfg_top,
  input  logic [NCOL*32-1:0]            cfg_bot,
  input  logic [NCOL-1:0]               cfg_axir,
  input  logic [NCOL-1:0]               cfg_axiw,
  input  logic                          bin_val,
  input  logic [br_bits(NCOL, DW)-1:0]  bin,
  output logic                          bin_rdy,
  input  logic                          ea_rbsy,
  input  logic                          ea_wbsy,
  output logic [DW/32-1:0]              rng_r,
  output logic [DW/32-1:0]              rng_w,
  output logic [$clog2(NCOL)-1:0]       lm_col,
  output logic [EXRING_ADDR_BITS-1:0]   lm_addr,
  output logic [DW/8-1:0]               lm_wm,
  output logic [DW-1:0]                 lm_wd,
  input  logic [DW-1:0]                 mr_data,
  output logic                          bout_val,
  output logic [br_bits(NCOL, DW)-1:0]  bout,
  input  logic                          bout_rdy
);

  localparam int unsigned COLB  = $clog2(NCOL);
  localparam int unsigned NLANE = DW / 32;
  localparam int unsigned LB    = $clog2(DW / 8);
  localparam int unsigned LW    = LB - 2;
  localparam int unsigned BRW   = br_bits(NCOL, DW);
  localparam int unsigned O_D   = off_d(DW);
  localparam int unsigned O_DM  = off_dm(DW);
  localparam int unsigned O_A   = off_a(DW);
  localparam int unsigned O_AV  = off_av(DW);
  localparam int unsigned O_COL = off_col(DW);
  localparam int unsigned O_TY  = off_ty(DW, COLB);
  localparam int unsigned O_RW  = off_rw(DW, COLB);
  localparam int unsigned QCW   = $clog2(DEPTH + 1);
  localparam int unsigned OCW   = $clog2(DEPTH + RD_LAT + 1);
  localparam int unsigned L     = RD_LAT - 1;

  logic                 f_rw, f_av;
  logic [2:0]           f_ty;
  logic [COLB-1:0]      f_col;
  logic [31:LB]         f_aline;
  logic [5:0]           f_arow;
  logic [CHIP_BITS-1:0] f_acdx;
  logic [DW/8-1:0]      f_dm;

  assign f_rw    = bin[O_RW];
  assign f_ty    = bin[O_TY +: 3];
  assign f_col   = bin[O_COL +: COLB];
  assign f_av    = bin[O_AV];
  assign f_aline = bin[O_A + LB +: 32 - LB];
  assign f_arow  = bin[O_A + 7 +: 6];
  assign f_acdx  = bin[O_A + 16 +: CHIP_BITS];
  assign f_dm    = bin[O_DM +: DW/8];

  logic [31:0]      top_sel, bot_sel, line, ftag, ltag;
  logic [NLANE-1:0] fmask, lmask, hit, lane_dm, merge_in;
  logic             unused_lowbits, local_hit, av_out;
  logic [BRW-1:0]   pkt_in, push_pkt, q_head;
  logic [QCW-1:0]   q_count;
  logic [OCW-1:0]   occ;
  logic             accept, pop;

  logic [BRW-1:0]   pkt_q [RD_LAT];
  logic [NLANE-1:0] mrg_q [RD_LAT];
  logic [RD_LAT-1:0] vld_q;

  // Per-column window select
  always_comb begin
    top_sel = '0;
    bot_sel = '0;
    for (int unsigned c = 0; c < NCOL; c++) begin
      if (f_col == COLB'(c)) begin
        top_sel = cfg_top[32*c +: 32];
        bot_sel = cfg_bot[32*c +: 32];
      end
    end
  end

  assign unused_lowbits = ^{top_sel[1:0], bot_sel[1:0]};

  // Line tags, partial-line lane masks and per-lane window hit
  always_comb begin
    line = {f_aline, LB'(0)};
    ftag = {top_sel[31:LB], LB'(0)};
    ltag = {bot_sel[31:LB], LB'(0)};
    for (int unsigned i = 0; i < NLANE; i++) begin
      fmask[i]   = (LW'(i) >= top_sel[LB-1:2]);
      lmask[i]   = (LW'(i) <= bot_sel[LB-1:2]);
      lane_dm[i] = |f_dm[4*i +: 4];
    end
    if ((line == ftag) && (line == ltag)) begin
      hit = fmask & lmask;
    end else if (line == ftag) begin
      hit = fmask;
    end else if (line == ltag) begin
      hit = lmask;
    end else if ((line > ftag) && (line < ltag)) begin
      hit = '1;
    end else begin
      hit = '0;
    end
  end

  // AXI range hits and LMM write strobes
  always_comb begin
    rng_r = (cfg_axir[f_col] && !f_rw && (f_ty == 3'd4)) ? hit : '0;
    rng_w = (cfg_axiw[f_col] &&  f_rw && (f_ty == 3'd4)) ? (hit & lane_dm) : '0;
    for (int unsigned i = 0; i < NLANE; i++) begin
      lm_wm[4*i +: 4] = rng_w[i] ? f_dm[4*i +: 4] : 4'h0;
    end
  end

  assign lm_wd   = bin[O_D +: DW];
  assign lm_addr = line[EXRING_ADDR_BITS-1:0];
  assign lm_col  = f_col;

  // Outgoing av and read-merge lanes latched at accept
  always_comb begin
    local_hit = ((f_acdx == chip) || (f_acdx == '0)) && (f_arow == l_row);
    av_out    = f_av | (|rng_r) | (|rng_w) | (local_hit & (f_ty < 3'd4));
    merge_in  = (f_ty < 3'd4) ? '0 : rng_r;
    pkt_in    = bin;
    pkt_in[O_AV] = av_out;
  end

  // Credits count in-flight pipeline stages plus queued entries
  always_comb begin
    occ = OCW'(q_count);
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      occ = occ + OCW'(vld_q[i]);
    end
    bin_rdy = (occ < OCW'(DEPTH)) && !((|rng_r) && ea_rbsy) && !((|rng_w) && ea_wbsy);
    accept  = bin_val && bin_rdy;
  end

  // Fixed-latency read pipeline, never stalls
  always_ff @(posedge ACLK or negedge RSTN) begin
    if (!RSTN) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pkt_q[i] <= '0;
        mrg_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= accept;
      pkt_q[0] <= pkt_in;
      mrg_q[0] <= merge_in;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        pkt_q[i] <= pkt_q[i-1];
        mrg_q[i] <= mrg_q[i-1];
      end
    end
  end

  // Last stage: replace hit read lanes with LMM data
  always_comb begin
    push_pkt = pkt_q[L];
    for (int unsigned i = 0; i < NLANE; i++) begin
      if (mrg_q[L][i]) begin
        push_pkt[O_D + 32*i +: 32] = mr_data[32*i +: 32];
      end
    end
  end

  assign bout_val = (q_count != '0);
  assign pop      = bout_val && bout_rdy;
  assign bout     = q_head;

  nbit_ndepth_queue #(
    .W     (BRW),
    .DEPTH (DEPTH)
  ) u_oq (
    .clk      (ACLK),
    .rst_n    (RSTN),
    .push_i   (vld_q[L]),
    .data_i   (push_pkt),
    .pop_i    (pop),
    .head_c_o (q_head),
    .count_o  (q_count)
  );

endmodule

// File: doc/lmring_node.md
LMRING_NODE -- requirements
Module: lmring_node

Interface
REQ-001 SHALL have parameter NCOL, default 4: number of columns served; COLB = clog2(NCOL).
REQ-002 SHALL have parameter DW, default 256: ring data width; NLANE = DW/32; LB = clog2(DW/8).
REQ-003 SHALL have parameter RD_LAT, default 1: LMM read latency in cycles; legal range 1..3.
REQ-004 SHALL have parameter DEPTH, default 4: output queue depth; DEPTH >= RD_LAT+1.
REQ-005 SHALL have port ACLK, input, 1: clock; all state on rising edge.
REQ-006 SHALL have port RSTN, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have ports chip (input, CHIP_BITS) and l_row (input, 6): node identity.
REQ-008 SHALL have ports cfg_top and cfg_bot, input, NCOL*32 each: per-column LMM byte-address window.
REQ-009 SHALL have ports cfg_axir and cfg_axiw, input, NCOL each: per-column AXI read/write enable.
REQ-010 SHALL have ports bin_val (input, 1), bin (input, BR_BITS) and bin_rdy (output, 1): ring input, valid/ready.
REQ-011 SHALL have ports ea_rbsy and ea_wbsy, input, 1 each: EA port busy.
REQ-012 SHALL have ports rng_r and rng_w, output, NLANE each: per-lane read/write hit, combinational from bin.
REQ-013 SHALL have outputs lm_col (COLB), lm_addr (EXRING_ADDR_BITS), lm_wm (DW/8) and lm_wd (DW): LMM access, combinational.
REQ-014 SHALL have port mr_data, input, DW: LMM read data, valid RD_LAT cycles after the accept.
REQ-015 SHALL have ports bout_val (output, 1), bout (output, BR_BITS) and bout_rdy (input, 1): ring output.

Function
REQ-016 SHALL form the packet as {rw, ty[2:0], col[COLB-1:0], sq[7:0], av, a[31:0], dm[DW/8-1:0], d[DW-1:0]}; line = a with bits [LB-1:0] cleared.
REQ-017 SHALL select cfg by bin.col; ftag/ltag = top/bot with low LB bits cleared; fmask lane i = (i >= top[LB-1:2]); lmask lane i = (i <= bot[LB-1:2]).
REQ-018 SHALL compute hit as: ftag<line<ltag gives all ones; line==ftag gives fmask; line==ltag gives lmask; both gives fmask&lmask; otherwise zero.
REQ-019 SHALL drive rng_r = hit when cfg_axir, rw=0, ty=4; otherwise 0.
REQ-020 SHALL drive rng_w = hit & lane(dm) when cfg_axiw, rw=1, ty=4, where lane(dm) = OR of each lane's 4 dm bits; otherwise 0.
REQ-021 SHALL drive lm_wm = dm gated per lane by rng_w; lm_wd = bin.d; lm_addr = line low bits; lm_col = bin.col.
REQ-022 SHALL hold an accept (bin_val & bin_rdy) only when all three hold: credits available, not (|rng_r & ea_rbsy), not (|rng_w & ea_wbsy).
REQ-023 SHALL define credits available as pipeline-occupancy + queue-count < DEPTH; bin_rdy is independent of bin_val.
REQ-024 SHALL carry accepted packets through an RD_LAT-stage valid pipeline, fixed latency and no stall; the queue push occurs in the RD_LAT-th cycle after accept.
REQ-025 SHALL set av_out = bin.av | (|rng_r) | (|rng_w) | (local & ty<4), where local = (cdx==chip or cdx==0) & a[12:7]==l_row and cdx = a[16+CHIP_BITS-1:16].
REQ-026 SHALL latch merge = (ty<4) ? 0 : rng_r at accept; at the last stage, d lane i = merge[i] ? mr_data lane i : d lane i.
REQ-027 SHALL keep all other packet fields unchanged.
REQ-028 SHALL make the queue FIFO-ordered with bout_val = non-empty; pop on bout_val & bout_rdy.
REQ-029 SHALL support simultaneous push and pop, and wrap pointers modulo DEPTH; the queue never overflows by construction.
REQ-030 SHALL, on a full queue with bout_rdy=0, hold bin_rdy=0 until a pop frees a credit; bin_rdy rises in the cycle after the pop.

Reset
REQ-031 SHALL, while RSTN=0, clear pipeline valids, queue pointers and count; bin_rdy=1 after reset, bout_val=0, bout=0.
REQ-032 SHALL discard in-flight packets on mid-operation reset; no partial push.

Structure
REQ-033 SHALL place field offsets, BR_BITS, CHIP_BITS and EXRING_ADDR_BITS as constants in shared package lmring_pkg.
REQ-034 SHALL instantiate one sub-module nbit_ndepth_queue for the output queue; range/mask logic stays inline.

Verification
REQ-035 SHALL cover: col1 top=0x1004, bot=0x1FF8, axir=1; read ty=4 a=0x1000 -> rng_r=0xFE; output lanes 1..7 from mr_data, lane0 from d, av=1.
REQ-036 SHALL cover: write ty=4 a=0x1FE0, dm=0x0000_000F -> rng_w=0x01, lm_wm=0x0000_000F; then ea_wbsy=1 -> bin_rdy=0, no accept.
REQ-037 SHALL cover: RD_LAT=2, DEPTH=4, bout_rdy=0, stream of 6 packets -> exactly 4 accepted, then bin_rdy=0; release bout_rdy -> order sq 0..5 preserved.
REQ-038 SHALL cover: ty=1, a[16+]=0, a[12:7]=l_row -> av=1, d unmerged; with a[12:7]!=l_row -> av=bin.av.
REQ-039 SHALL cover: RSTN pulsed low with 2 packets in flight -> bout_val=0 next cycle and no stale output afterwards.
REQ-040 SHALL cover: DEPTH=3 with push and pop every cycle for 20 cycles -> count constant, pointers wrap, no loss.
